// File: rtl/parking_emu_pkg.sv
// Shared types and sensor patterns for the parking-lot gate emulator.
package parking_emu_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      S_FIRST  = 3'd1,
      S_BOTH   = 3'd2,
      S_SECOND = 3'd3,
      S_CLEAR  = 3'd4
   } emu_state_t;

   localparam logic [1:0] PAT_ENTER_FIRST = 2'b10;
   localparam logic [1:0] PAT_EXIT_FIRST  = 2'b01;
   localparam logic [1:0] PAT_BOTH        = 2'b11;
   localparam logic [1:0] PAT_CLEAR       = 2'b00;

   // {a,b} shown while in a given state; dir = 1 mirrors the enter pattern.
   function automatic logic [1:0] state_pattern(input emu_state_t st, input logic dir);
      logic [1:0] pat;
      case (st)
         S_FIRST:  pat = dir ? PAT_EXIT_FIRST : PAT_ENTER_FIRST;
         S_BOTH:   pat = PAT_BOTH;
         S_SECOND: pat = dir ? PAT_ENTER_FIRST : PAT_EXIT_FIRST;
         default:  pat = PAT_CLEAR;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/parking_sensor_emulator_phase_timer.sv
// Per-phase down-counter; a zero length is stretched to one cycle.
module phase_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DWELL_W-1:0] length,
   output logic               expire
);

   logic [DWELL_W-1:0] count_q;
   logic [DWELL_W-1:0] count_d;

   // Load max(length,1)-1 on phase entry, then count down and hold at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         if (length == '0) begin
            count_d = '0;
         end else begin
            count_d = length - DWELL_W'(1);
         end
      end else if (count_q != '0) begin
         count_d = count_q - DWELL_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/parking_sensor_emulator.sv
// Emulates photosensors a/b for one car entering, exiting or balking per start request.
module parking_sensor_emulator
   import parking_emu_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               dir,
   input  logic               balk,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               abort,
   output logic               a,
   output logic               b,
   output logic               busy,
   output logic               done
);

   emu_state_t         state_q, state_d;
   logic               dir_q, dir_d;
   logic               balk_q, balk_d;
   logic               backed_q, backed_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         ab_q, ab_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               load_s;
   logic               expire_s;
   logic [DWELL_W-1:0] timer_len_s;

   // The start edge must load the live dwell since the latch is not yet updated.
   assign timer_len_s = (state_q == IDLE) ? dwell : dwell_q;

   phase_timer #(.DWELL_W(DWELL_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .length (timer_len_s),
      .expire (expire_s)
   );

   // Next-state, latch capture and registered-output values.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      balk_d   = balk_q;
      backed_d = backed_q;
      dwell_d  = dwell_q;
      load_s   = 1'b0;
      done_d   = 1'b0;
      if ((state_q != IDLE) && abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dir_d    = dir;
                  balk_d   = balk;
                  dwell_d  = dwell;
                  backed_d = 1'b0;
                  load_s   = 1'b1;
                  state_d  = S_FIRST;
               end else begin
                  state_d = IDLE;
               end
            end
            S_FIRST: begin
               if (expire_s) begin
                  load_s  = 1'b1;
                  state_d = backed_q ? S_CLEAR : S_BOTH;
               end else begin
                  state_d = S_FIRST;
               end
            end
            S_BOTH: begin
               if (expire_s) begin
                  load_s   = 1'b1;
                  backed_d = balk_q;
                  state_d  = balk_q ? S_FIRST : S_SECOND;
               end else begin
                  state_d = S_BOTH;
               end
            end
            S_SECOND: begin
               if (expire_s) begin
                  load_s  = 1'b1;
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_SECOND;
               end
            end
            S_CLEAR: begin
               if (expire_s) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_CLEAR;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      ab_d   = state_pattern(state_d, dir_d);
      busy_d = (state_d != IDLE);
   end

   // State, latched event parameters and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         dir_q    <= 1'b0;
         balk_q   <= 1'b0;
         backed_q <= 1'b0;
         dwell_q  <= '0;
         ab_q     <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         balk_q   <= balk_d;
         backed_q <= backed_d;
         dwell_q  <= dwell_d;
         ab_q     <= ab_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign a    = ab_q[1];
   assign b    = ab_q[0];
   assign busy = busy_q;
   assign done = done_q;

endmodule
